debug_autobaud: RTL and testbench

//  Auto-baud detector for the debug UART. Measures an incoming 0x55 ('U') sync character on rx.

---
 rtl/debug_autobaud_pkg.sv | 16 +
 rtl/debug_sync2.sv | 24 ++
 rtl/debug_autobaud.sv | 176 +++++++++++++++++
 tb/tb_debug_autobaud.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_autobaud_pkg.sv
// Shared definitions for the debug UART auto-baud detector and its baud generator.
package debug_autobaud_pkg;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_WAIT,
        ST_MEAS,
        ST_CALC,
        ST_LOCKED
    } state_e;

    localparam logic [7:0] SYNC_CHAR      = 8'h55;
    localparam logic [6:0] DEF_BAUD_DIV   = 7'h0C;
    localparam int         EDGES_PER_SYNC = 4;

endpackage

// File: rtl/debug_sync2.sv
// Two-flop synchronizer for the raw rx pad; resets to the idle-high line level.
module debug_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/debug_autobaud.sv
// Auto-baud detector: times the falling edges of a 0x55 sync character on rx and
// produces the divider for the debug baud generator (bit time = 16*(div+1) clks).
module debug_autobaud
    import debug_autobaud_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int IDLE_MIN = 16,
    parameter int TOL_SH   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       relock_i,
    input  logic       rx_i,
    output logic       baud_set_o,
    output logic [6:0] baud_div_o,
    output logic       locked_o,
    output logic       err_o
);

    localparam int IDLE_W = $clog2(IDLE_MIN + 1);
    localparam int EDGE_W = $clog2(EDGES_PER_SYNC);

    state_e              state_q, state_d;
    logic                rxSync;
    logic                rxPrev_q;
    logic                rxFall;
    logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;
    logic [CNT_W-1:0]    segCnt_q, segCnt_d;
    logic [CNT_W-1:0]    totCnt_q, totCnt_d;
    logic [CNT_W-1:0]    refSeg_q, refSeg_d;
    logic [EDGE_W-1:0]   edgeIdx_q, edgeIdx_d;
    logic [6:0]          baudDiv_q, baudDiv_d;
    logic                baudSet_q, baudSet_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    segLen;
    logic [CNT_W-1:0]    segDiff;
    logic [CNT_W-1:0]    segTol;
    logic [CNT_W:0]      roundSum;
    logic [CNT_W:0]      quot;
    logic                quotValid;

    debug_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rxSync)
    );

    // Segment length includes the edge cycle itself, so the count equals the true edge spacing.
    assign rxFall    = rxPrev_q & ~rxSync;
    assign segLen    = segCnt_q + 1'b1;
    assign segDiff   = (segLen >= refSeg_q) ? (segLen - refSeg_q) : (refSeg_q - segLen);
    assign segTol    = refSeg_q >> TOL_SH;
    assign roundSum  = {1'b0, totCnt_q} + (CNT_W+1)'(64);
    assign quot      = roundSum >> 7;
    assign quotValid = (quot != '0) && (quot <= (CNT_W+1)'(128));

    always_comb begin
        state_d   = state_q;
        idleCnt_d = idleCnt_q;
        segCnt_d  = segCnt_q;
        totCnt_d  = totCnt_q;
        refSeg_d  = refSeg_q;
        edgeIdx_d = edgeIdx_q;
        baudDiv_d = baudDiv_q;
        locked_d  = locked_q;
        baudSet_d = 1'b0;
        err_d     = 1'b0;

        if (!en_i || relock_i) begin
            state_d   = ST_ARM;
            locked_d  = 1'b0;
            idleCnt_d = '0;
            segCnt_d  = '0;
            totCnt_d  = '0;
            edgeIdx_d = '0;
        end else begin
            unique case (state_q)
                ST_ARM: begin
                    if (!rxSync) begin
                        idleCnt_d = '0;
                    end else if (idleCnt_q == IDLE_W'(IDLE_MIN - 1)) begin
                        idleCnt_d = '0;
                        state_d   = ST_WAIT;
                    end else begin
                        idleCnt_d = idleCnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (rxFall) begin
                        segCnt_d  = '0;
                        totCnt_d  = '0;
                        edgeIdx_d = '0;
                        state_d   = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if ((&segCnt_q) || (&totCnt_q)) begin
                        err_d   = 1'b1;
                        state_d = ST_ARM;
                    end else if (rxFall) begin
                        segCnt_d = '0;
                        totCnt_d = totCnt_q + 1'b1;
                        if (edgeIdx_q == '0) begin
                            refSeg_d  = segLen;
                            edgeIdx_d = edgeIdx_q + 1'b1;
                        end else if (segDiff > segTol) begin
                            err_d   = 1'b1;
                            state_d = ST_ARM;
                        end else if (edgeIdx_q == EDGE_W'(EDGES_PER_SYNC - 1)) begin
                            state_d = ST_CALC;
                        end else begin
                            edgeIdx_d = edgeIdx_q + 1'b1;
                        end
                    end else begin
                        segCnt_d = segCnt_q + 1'b1;
                        totCnt_d = totCnt_q + 1'b1;
                    end
                end
                ST_CALC: begin
                    if (quotValid) begin
                        baudDiv_d = 7'(quot - 1'b1);
                        baudSet_d = 1'b1;
                        locked_d  = 1'b1;
                        state_d   = ST_LOCKED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ARM;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d = ST_ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARM;
            rxPrev_q  <= 1'b1;
            idleCnt_q <= '0;
            segCnt_q  <= '0;
            totCnt_q  <= '0;
            refSeg_q  <= '0;
            edgeIdx_q <= '0;
            baudDiv_q <= DEF_BAUD_DIV;
            baudSet_q <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rxPrev_q  <= rxSync;
            idleCnt_q <= idleCnt_d;
            segCnt_q  <= segCnt_d;
            totCnt_q  <= totCnt_d;
            refSeg_q  <= refSeg_d;
            edgeIdx_q <= edgeIdx_d;
            baudDiv_q <= baudDiv_d;
            baudSet_q <= baudSet_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    assign baud_set_o = baudSet_q;
    assign baud_div_o = baudDiv_q;
    assign locked_o   = locked_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_debug_autobaud.sv
// Scoreboard bench for debug_autobaud: each frame pushes its expected outcome, a monitor
// pops and checks on every baud_set/err pulse.
module tb_debug_autobaud;
    import debug_autobaud_pkg::*;

    // 15-bit counters still hold the longest valid frame while keeping the timeout run short.
    localparam int CNT_W = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i = 1'b0;
    logic       relock_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       baud_set_o;
    logic [6:0] baud_div_o;
    logic       locked_o;
    logic       err_o;

    typedef struct packed {
        bit         isErr;
        logic [6:0] div;
    } exp_t;

    exp_t       expQ[$];
    exp_t       popped;
    int         errors = 0;
    int         checks = 0;
    logic [6:0] lastDiv = 7'h0C;

    debug_autobaud #(.CNT_W(CNT_W), .IDLE_MIN(16), .TOL_SH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .relock_i   (relock_i),
        .rx_i       (rx_i),
        .baud_set_o (baud_set_o),
        .baud_div_o (baud_div_o),
        .locked_o   (locked_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && (baud_set_o || err_o)) begin
            checks++;
            if (baud_set_o && err_o) begin
                errors++;
                $display("[TB] FAIL pulseExclusive: baud_set=1 err=1, required only one");
            end else if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedPulse: baud_set=%0b err=%0b div=%0d, required no pulse",
                         baud_set_o, err_o, baud_div_o);
            end else begin
                popped = expQ.pop_front();
                if (popped.isErr !== err_o || (!popped.isErr && baud_div_o !== popped.div)) begin
                    errors++;
                    $display("[TB] FAIL result: err=%0b div=%0d, required err=%0b div=%0d",
                             err_o, baud_div_o, popped.isErr, popped.div);
                end
            end
        end
    end

    function automatic exp_t model(input int s0, input int s1, input int s2, input int s3);
        int   segs[4];
        int   d;
        int   n;
        int   q;
        exp_t r;
        segs = '{s0, s1, s2, s3};
        r.isErr = 1'b0;
        r.div   = lastDiv;
        for (int i = 1; i < 4; i++) begin
            d = segs[i] - s0;
            if (d < 0) d = -d;
            if (d > (s0 >> 3)) r.isErr = 1'b1;
        end
        n = s0 + s1 + s2 + s3;
        q = (n + 64) >> 7;
        if (q < 1 || q > 128) r.isErr = 1'b1;
        if (!r.isErr) r.div = 7'(q - 1);
        return r;
    endfunction

    task automatic holdRx(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseRelock();
        relock_i = 1'b1;
        @(negedge clk);
        relock_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDrain(input int budget, input string name, output int cyc);
        cyc = 0;
        while (expQ.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: %0d results pending after %0d cycles, required 0",
                     name, expQ.size(), cyc);
            expQ.delete();
        end
    endtask

    // Start bit plus data bits of the sync char; the last low bit is cut short since the
    // measurement ends on its falling edge.
    task automatic sendFrame(input int b);
        logic [7:0] ch;
        ch = SYNC_CHAR;
        holdRx(1'b0, b);
        for (int i = 0; i < 7; i++) holdRx(ch[i], b);
        holdRx(ch[7], (b < 8) ? b : 8);
        holdRx(1'b1, 20);
    endtask

    task automatic runFrame(input int b, input string name);
        exp_t e;
        int   cyc;
        e = model(2 * b, 2 * b, 2 * b, 2 * b);
        expQ.push_back(e);
        if (!e.isErr) lastDiv = e.div;
        holdRx(1'b1, 20);
        sendFrame(b);
        waitDrain(100, name, cyc);
        checks++;
        if (locked_o !== !e.isErr) begin
            errors++;
            $display("[TB] FAIL %s locked: got %0b, required %0b", name, locked_o, !e.isErr);
        end
        checks++;
        if (baud_div_o !== lastDiv) begin
            errors++;
            $display("[TB] FAIL %s div: got %0d, required %0d", name, baud_div_o, lastDiv);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checks++;
        if (baud_set_o !== 1'b0 || err_o !== 1'b0 || locked_o !== 1'b0 || baud_div_o !== 7'h0C) begin
            errors++;
            $display("[TB] FAIL %s: set=%0b err=%0b locked=%0b div=%0d, required 0 0 0 12",
                     name, baud_set_o, err_o, locked_o, baud_div_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("resetState");
        rst_n = 1'b1;
        en_i  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lock208();
        runFrame(208, "lock208");
    endtask

    task automatic test_range();
        pulseRelock();
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL relockDrop: locked=%0b, required 0", locked_o);
        end
        runFrame(48, "frame48");
        pulseRelock();
        runFrame(2048, "frame2048");
    endtask

    task automatic test_tolerance();
        int cyc;
        pulseRelock();
        expQ.push_back(model(416, 480, 416, 416));
        holdRx(1'b1, 20);
        holdRx(1'b0, 208);
        holdRx(1'b1, 208);
        holdRx(1'b0, 240);
        holdRx(1'b1, 240);
        holdRx(1'b0, 30);
        holdRx(1'b1, 20);
        waitDrain(100, "tolerance", cyc);
        checks++;
        if (locked_o !== 1'b0 || baud_div_o !== lastDiv) begin
            errors++;
            $display("[TB] FAIL toleranceKeep: locked=%0b div=%0d, required 0 %0d",
                     locked_o, baud_div_o, lastDiv);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   cyc;
        e.isErr = 1'b1;
        e.div   = lastDiv;
        expQ.push_back(e);
        holdRx(1'b1, 20);
        rx_i = 1'b0;
        waitDrain((1 << CNT_W) + 40, "timeout", cyc);
        checks++;
        if (cyc < (1 << CNT_W) - 1 || cyc > (1 << CNT_W) + 12) begin
            errors++;
            $display("[TB] FAIL timeoutDelay: err after %0d cycles, required about %0d",
                     cyc, (1 << CNT_W) + 3);
        end
        checks++;
        if (baud_div_o !== lastDiv || locked_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeoutKeep: div=%0d locked=%0b, required %0d 0",
                     baud_div_o, locked_o, lastDiv);
        end
        rx_i = 1'b1;
        runFrame(208, "afterTimeout");
    endtask

    task automatic test_out_of_range();
        pulseRelock();
        runFrame(4, "tooFast");
        runFrame(2112, "tooSlow");
    endtask

    task automatic test_relock_reset_en();
        runFrame(48, "lock48");
        pulseRelock();
        checks++;
        if (locked_o !== 1'b0 || baud_div_o !== lastDiv) begin
            errors++;
            $display("[TB] FAIL relock: locked=%0b div=%0d, required 0 %0d",
                     locked_o, baud_div_o, lastDiv);
        end
        holdRx(1'b1, 20);
        holdRx(1'b0, 48);
        holdRx(1'b1, 48);
        holdRx(1'b0, 20);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("resetMidFrame");
        lastDiv = 7'h0C;
        rx_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        holdRx(1'b1, 20);
        holdRx(1'b0, 48);
        holdRx(1'b1, 48);
        holdRx(1'b0, 20);
        en_i = 1'b0;
        holdRx(1'b1, 40);
        checks++;
        if (locked_o !== 1'b0 || baud_div_o !== lastDiv) begin
            errors++;
            $display("[TB] FAIL enableDrop: locked=%0b div=%0d, required 0 %0d",
                     locked_o, baud_div_o, lastDiv);
        end
        en_i = 1'b1;
        runFrame(208, "afterEnable");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lock208();
        test_range();
        test_tolerance();
        test_timeout();
        test_out_of_range();
        test_relock_reset_en();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
